// File: rtl/score_display_multi.sv
// Score overlay: binary score -> BCD via sequential double-dabble,
// frame-synchronised commit, scaled 5x7 glyph rendering with
// leading-zero blanking.
// Ports: clk, rst_n (sync, active-low), pix_x/pix_y (pixel position),
//   frame_start (vblank pulse), score/load (conversion request),
//   busy, overflow (saturated commit), pixel_on (registered glyph pixel).
// Optional: define SCORE_FLASH_EN to flash the field after a changed commit.
module score_display_multi #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCORE_X    = 16,
  parameter int SCORE_Y    = 16,
  parameter int SCALE      = 3,
  parameter int GAP        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pix_x,
  input  logic [8:0]       pix_y,
  input  logic             frame_start,
  input  logic [BIN_W-1:0] score,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic             pixel_on
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CW      = $clog2(BIN_W + 1);
  localparam int PITCH   = 5 * SCALE + GAP;
  localparam int FIELD_W = NUM_DIGITS * PITCH - GAP;
  localparam int FIELD_H = 7 * SCALE;
  localparam logic [BIN_W-1:0] LIMIT = BIN_W'(10 ** NUM_DIGITS);
  localparam logic [DW-1:0]    NINES = {NUM_DIGITS{4'h9}};

  // Rows top to bottom, MSB of each row is the leftmost column.
  localparam logic [34:0] FONT [16] = '{
    {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
    {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
    {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
    {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
    {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
    {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
    {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
    {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
    {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
    {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},
    35'd0, 35'd0, 35'd0, 35'd0, 35'd0, 35'd0
  };

  typedef enum logic [1:0] {
    IDLE, CONVERT, WAIT_FRAME, COMMIT
  } state_t;

  state_t          state, state_nx;
  logic [BIN_W-1:0] bin;
  logic [DW-1:0]   bcd, bcd_adj, disp, result;
  logic [CW-1:0]   cnt;
  logic            sat;
  logic            mask;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (load) state_nx = CONVERT;
      CONVERT:    if (cnt == CW'(BIN_W - 1)) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) state_nx = COMMIT;
      COMMIT:     state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign result = sat ? NINES : bcd;

  // Digits above NUM_DIGITS fall off the top of the accumulator;
  // those values are saturated anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (load) begin
          bin <= score;
          bcd <= '0;
          cnt <= '0;
          sat <= (score >= LIMIT);
        end
        CONVERT: begin
          bcd <= {bcd_adj[DW-2:0], bin[BIN_W-1]};
          bin <= bin << 1;
          cnt <= cnt + CW'(1);
        end
        COMMIT: begin
          disp     <= result;
          overflow <= sat;
        end
        default: ;
      endcase
    end
  end

`ifdef SCORE_FLASH_EN
  logic [6:0] flash;

  always_ff @(posedge clk) begin
    if (!rst_n)
      flash <= '0;
    else if (state == COMMIT && result != disp)
      flash <= 7'd64;
    else if (frame_start && flash != 7'd0)
      flash <= flash - 7'd1;
  end

  assign mask = (flash != 7'd0) && flash[3];
`else
  assign mask = 1'b0;
`endif

  function automatic logic [4:0] glyph_row(
    input logic [3:0] d,
    input logic [2:0] r
  );
    logic [34:0] g;
    g = FONT[d];
    glyph_row = '0;
    unique case (r)
      3'd0: glyph_row = g[34:30];
      3'd1: glyph_row = g[29:25];
      3'd2: glyph_row = g[24:20];
      3'd3: glyph_row = g[19:15];
      3'd4: glyph_row = g[14:10];
      3'd5: glyph_row = g[9:5];
      3'd6: glyph_row = g[4:0];
      default: glyph_row = '0;
    endcase
  endfunction

  int         dx, dy, di, off, col, row;
  logic       in_field, lead, blank, hit;
  logic [3:0] dsel;
  logic [4:0] gl;

  always_comb begin
    dx       = int'(pix_x) - SCORE_X;
    dy       = int'(pix_y) - SCORE_Y;
    in_field = (dx >= 0) && (dx < FIELD_W) &&
               (dy >= 0) && (dy < FIELD_H);
    di       = dx / PITCH;
    off      = dx % PITCH;
    col      = off / SCALE;
    row      = dy / SCALE;
    dsel     = '0;
    lead     = 1'b1;
    blank    = 1'b0;
    // lead stays set while every digit up to and including i is zero
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) lead = 1'b0;
      if (i == di) begin
        dsel  = disp[4*(NUM_DIGITS-1-i) +: 4];
        blank = lead && (i != NUM_DIGITS - 1);
      end
    end
    gl  = glyph_row(dsel, 3'(row));
    hit = in_field && (off < 5 * SCALE) && !blank &&
          gl[3'(4 - col)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pixel_on <= 1'b0;
    else        pixel_on <= hit && !mask;
  end

endmodule

// File: tb/tb_score_display_multi.sv
// Self-checking bench for score_display_multi (default parameters).
// Scoreboard of committed values; field scans against a pixel model.
module tb_score_display_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [8:0]  pix_y = '0;
  logic        frame_start = 1'b0;
  logic [13:0] score = '0;
  logic        load = 1'b0;
  logic        busy, overflow, pixel_on;

  always #5 clk = ~clk;

  score_display_multi dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .score(score), .load(load),
    .busy(busy), .overflow(overflow), .pixel_on(pixel_on)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   v;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  int cur_val = 0;
  int flash_cnt = 0;

  localparam logic [4:0] FONT_T [10][7] = '{
    '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
    '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
    '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
    '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
    '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
    '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
    '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
    '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
    '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
    '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C}
  };

  // Field at (16,16), pitch 19, glyph cell 15x21, four digits.
  function automatic logic exp_pix(int x, int y);
    int dx, dy, di, off, p, d, col, row;
    dx = x - 16;
    dy = y - 16;
    if (dx < 0 || dy < 0 || dx >= 72 || dy >= 21) return 1'b0;
    di  = dx / 19;
    off = dx % 19;
    if (off >= 15) return 1'b0;
    p = 10 ** (3 - di);
    if (di != 3 && (cur_val / p) == 0) return 1'b0;
    if (flash_cnt != 0 && (flash_cnt & 8) != 0) return 1'b0;
    d   = (cur_val / p) % 10;
    col = off / 3;
    row = dy / 3;
    return FONT_T[d][row][4-col];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input string name);
    int bad = 0;
    int bx = 0, by = 0;
    logic bgot = 1'b0, bwant = 1'b0;
    for (int y = 14; y <= 38; y++) begin
      for (int x = 12; x <= 92; x++) begin
        pix_x = 10'(x);
        pix_y = 9'(y);
        tick();
        if (pixel_on !== exp_pix(x, y)) begin
          if (bad == 0) begin
            bx = x; by = y; bgot = pixel_on; bwant = exp_pix(x, y);
          end
          bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL scan_%s: %0d bad pixels, first (%0d,%0d) got %b want %b",
               name, bad, bx, by, bgot, bwant);
    end
  endtask

  task automatic run_load(input string name, input int s, input int fs_at,
                          input int second_at, input int second_s);
    exp_t e;
    logic want;
    pix_x = 10'd22;
    pix_y = 9'd16;
    score = 14'(s);
    load  = 1'b1;
    e.v   = (s >= 10000) ? 9999 : s;
    e.ovf = (s >= 10000);
    sb.push_back(e);
    for (int k = 1; k <= fs_at; k++) begin
      tick();
      load = 1'b0;
      if (k == second_at) begin
        score = 14'(second_s);
        load  = 1'b1;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_hold_%s: cycle %0d got %b want 1", name, k, busy);
      end
      if (k == fs_at) begin
        want = exp_pix(22, 16);
        checks++;
        if (pixel_on !== want) begin
          failures++;
          $display("FAIL no_tear_%s: got %b want %b", name, pixel_on, want);
        end
        frame_start = 1'b1;
      end
    end
    tick();
    frame_start = 1'b0;
    if (flash_cnt > 0) flash_cnt--;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_commit_%s: got %b want 1", name, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop_%s: got %b want 0", name, busy);
    end
    e = sb.pop_front();
    checks++;
    if (overflow !== e.ovf) begin
      failures++;
      $display("FAIL overflow_%s: got %b want %b", name, overflow, e.ovf);
    end
    if (e.v != cur_val) flash_cnt = 64;
    cur_val = e.v;
    scan(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (pixel_on !== 1'b0) begin
      failures++;
      $display("FAIL reset_pixel: got %b want 0", pixel_on);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    scan("reset");
  endtask

  task automatic test_convert();
    run_load("s1234", 1234, 40, -1, 0);
  endtask

  task automatic test_blanking();
    run_load("s7", 7, 15, -1, 0);
    run_load("s0", 0, 20, -1, 0);
  endtask

  task automatic test_saturation();
    run_load("s12000", 12000, 18, -1, 0);
    run_load("s42", 42, 16, -1, 0);
  endtask

  task automatic test_busy_ignore();
    run_load("s55_ignore66", 55, 15, 3, 66);
  endtask

  task automatic test_reset_mid_convert();
    pix_x = 10'd22;
    pix_y = 9'd16;
    score = 14'd999;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cur_val = 0;
    flash_cnt = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_busy: got %b want 0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_overflow: got %b want 0", overflow);
    end
    repeat (20) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_no_commit: busy got %b want 0", busy);
    end
    scan("rst_mid");
  endtask

`ifdef SCORE_FLASH_EN
  task automatic test_flash();
    logic want;
    run_load("f5", 5, 15, -1, 0);
    run_load("f6", 6, 15, -1, 0);
    pix_x = 10'd73;
    pix_y = 9'd25;
    for (int f = 0; f < 20; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (flash_cnt > 0) flash_cnt--;
      tick();
      want = exp_pix(73, 25);
      checks++;
      if (pixel_on !== want) begin
        failures++;
        $display("FAIL flash_frame%0d: got %b want %b", f, pixel_on, want);
      end
    end
    run_load("f6_again", 6, 15, -1, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_saturation();
    test_busy_ignore();
    test_reset_mid_convert();
`ifdef SCORE_FLASH_EN
    test_flash();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
